interpolator: RTL

- Single-clock polyphase FIR interpolator; the upsampling counterpart to the MSO capture-path decimator.
- Accepts one signed sample per handshake and emits INTERP_FACTOR filtered output samples per input, one output per phase.
- Uses one time-shared multiply-accumulate unit.
- Feeds the display/reconstruction path, where captured records are upsampled before rendering.

---
 rtl/mso_dsp_pkg.sv | 38 +++
 rtl/interpolator_if.sv | 26 ++
 rtl/interpolator_mac.sv | 33 +++
 rtl/interpolator.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/mso_dsp_pkg.sv
// mso_dsp_pkg: shared definitions for the MSO DSP blocks (interpolator now,
// decimator later).
//   fsm_state_t  : IDLE / MAC / EMIT states of the time-shared MAC engines
//   Q_OUT_SHIFT  : default output shift for Q1.7 coefficients
//   clog2        : ceil(log2(v)), usable in constant expressions
//   sat_signed   : clamp a sign-extended 64-bit value into a w-bit signed range
package mso_dsp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_EMIT = 2'd2
  } fsm_state_t;

  localparam int unsigned Q_OUT_SHIFT = 7;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Callers sign-extend into 64 bits and truncate the result back to w bits.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                    input int unsigned        w);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (w - 1));
    if (v > max_v)      return max_v;
    else if (v < min_v) return min_v;
    else                return v;
  endfunction

endpackage

// File: rtl/interpolator_if.sv
// interpolator_if: sample stream handshakes of the interpolator.
//   src_*  : upstream samples into the block (valid/ready)
//   dest_* : filtered output samples (valid/ready)
//   master : the side that produces src samples and consumes dest samples
//   slave  : the interpolator itself
interface interpolator_if #(
  parameter int unsigned SRC_DATA_WIDTH  = 12,
  parameter int unsigned DEST_DATA_WIDTH = 12
);
  logic signed [SRC_DATA_WIDTH-1:0]  src_data;
  logic                              src_valid;
  logic                              src_ready;
  logic signed [DEST_DATA_WIDTH-1:0] dest_data;
  logic                              dest_valid;
  logic                              dest_ready;

  modport master (
    output src_data, src_valid, dest_ready,
    input  src_ready, dest_data, dest_valid
  );

  modport slave (
    input  src_data, src_valid, dest_ready,
    output src_ready, dest_data, dest_valid
  );
endinterface

// File: rtl/interpolator_mac.sv
// fir_mac: signed multiply-accumulate slice shared by all taps and phases.
//   clk, rst : clock, synchronous active-high reset
//   i_clr    : zero the accumulator (wins over i_en)
//   i_en     : accumulate i_a * i_b
//   i_a, i_b : signed operands
//   o_acc    : registered accumulator
//   o_sum    : o_acc + i_a*i_b, combinational (lets the last tap skip a cycle)
module fir_mac #(
  parameter int unsigned A_WIDTH   = 12,
  parameter int unsigned B_WIDTH   = 8,
  parameter int unsigned ACC_WIDTH = 22
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_clr,
  input  logic                        i_en,
  input  logic signed [A_WIDTH-1:0]   i_a,
  input  logic signed [B_WIDTH-1:0]   i_b,
  output logic signed [ACC_WIDTH-1:0] o_acc,
  output logic signed [ACC_WIDTH-1:0] o_sum
);
  logic signed [A_WIDTH+B_WIDTH-1:0] w_prod;
  logic signed [ACC_WIDTH-1:0]       r_acc;

  assign w_prod = i_a * i_b;
  assign o_sum  = r_acc + ACC_WIDTH'(w_prod);
  assign o_acc  = r_acc;

  always_ff @(posedge clk) begin
    if (rst || i_clr) r_acc <= '0;
    else if (i_en)    r_acc <= o_sum;
  end
endmodule

// File: rtl/interpolator.sv
// interpolator: polyphase FIR interpolator, INTERP_FACTOR outputs per input,
// one time-shared MAC. Each phase p sums coeff[k*L+p]*x[k] over k=0..TPP-1.
//   clk   : clock
//   rst   : synchronous active-high reset (aborts pending phases, clears delay line)
//   coeff : NUM_TAPS signed taps, tap i at [i*COEFF_WIDTH +: COEFF_WIDTH]
//   bus   : interpolator_if.slave (src_* input stream, dest_* output stream)
// Optional macro INTERPOLATOR_ROUND_EN: add 2^(OUT_SHIFT-1) before the shift
// (round half up); otherwise the shift floors.
module interpolator
  import mso_dsp_pkg::*;
#(
  parameter int unsigned SRC_DATA_WIDTH  = 12,
  parameter int unsigned DEST_DATA_WIDTH = 12,
  parameter int unsigned COEFF_WIDTH     = 8,
  parameter int unsigned NUM_TAPS        = 8,
  parameter int unsigned INTERP_FACTOR   = 2,
  parameter int unsigned OUT_SHIFT       = Q_OUT_SHIFT
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_TAPS*COEFF_WIDTH-1:0] coeff,
  interpolator_if.slave                   bus
);
  localparam int unsigned TPP       = NUM_TAPS / INTERP_FACTOR;
  localparam int unsigned ACC_WIDTH = SRC_DATA_WIDTH + COEFF_WIDTH + clog2(TPP);
  localparam int unsigned K_W       = (clog2(TPP) > 0) ? clog2(TPP) : 1;
  localparam int unsigned PH_W      = clog2(INTERP_FACTOR);
  localparam logic [K_W-1:0]  K_LAST  = K_W'(TPP - 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(INTERP_FACTOR - 1);

  if ((INTERP_FACTOR < 2) || ((NUM_TAPS % INTERP_FACTOR) != 0)) begin : g_bad_cfg
    $error("interpolator: NUM_TAPS must be a multiple of INTERP_FACTOR >= 2");
  end

  fsm_state_t                        r_state;
  logic signed [SRC_DATA_WIDTH-1:0]  r_x [TPP];
  logic [PH_W-1:0]                   r_phase;
  logic [K_W-1:0]                    r_k;
  logic                              r_src_ready;
  logic                              r_dest_valid;
  logic signed [DEST_DATA_WIDTH-1:0] r_dest_data;

  logic [31:0]                       w_tap_idx;
  logic signed [COEFF_WIDTH-1:0]     w_coef;
  logic signed [SRC_DATA_WIDTH-1:0]  w_x_sel;
  logic                              w_accept;
  logic                              w_out_hs;
  logic                              w_mac_clr;
  logic                              w_mac_en;
  logic signed [ACC_WIDTH-1:0]       w_acc;
  logic signed [ACC_WIDTH-1:0]       w_sum;
  logic signed [ACC_WIDTH:0]         w_pre;
  logic signed [ACC_WIDTH:0]         w_shifted;
  logic signed [DEST_DATA_WIDTH-1:0] w_dest;

  assign bus.src_ready  = r_src_ready;
  assign bus.dest_valid = r_dest_valid;
  assign bus.dest_data  = r_dest_data;

  assign w_accept = (r_state == ST_IDLE) && bus.src_valid;
  assign w_out_hs = (r_state == ST_EMIT) && bus.dest_ready;

  always_comb begin
    w_tap_idx = 32'(r_k) * INTERP_FACTOR + 32'(r_phase);
    w_coef    = coeff[w_tap_idx*COEFF_WIDTH +: COEFF_WIDTH];
    w_x_sel   = r_x[r_k];
  end

  // The accumulator is zeroed on the same edge that starts a phase, so the
  // first MAC cycle always begins from zero.
  assign w_mac_clr = w_accept || (w_out_hs && (r_phase != PH_LAST));
  assign w_mac_en  = (r_state == ST_MAC);

  fir_mac #(
    .A_WIDTH   (SRC_DATA_WIDTH),
    .B_WIDTH   (COEFF_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_mac_clr),
    .i_en  (w_mac_en),
    .i_a   (w_x_sel),
    .i_b   (w_coef),
    .o_acc (w_acc),
    .o_sum (w_sum)
  );

  // One guard bit so the rounding constant cannot wrap before saturation.
`ifdef INTERPOLATOR_ROUND_EN
  localparam logic signed [ACC_WIDTH:0] RND_HALF = (ACC_WIDTH + 1)'(1) <<< (OUT_SHIFT - 1);
  assign w_pre = $signed({w_sum[ACC_WIDTH-1], w_sum}) + RND_HALF;
`else
  assign w_pre = $signed({w_sum[ACC_WIDTH-1], w_sum});
`endif
  assign w_shifted = w_pre >>> OUT_SHIFT;
  assign w_dest    = DEST_DATA_WIDTH'(sat_signed(64'(w_shifted), DEST_DATA_WIDTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_src_ready  <= 1'b1;
      r_dest_valid <= 1'b0;
      r_dest_data  <= '0;
      r_phase      <= '0;
      r_k          <= '0;
      for (int unsigned i = 0; i < TPP; i++) r_x[i] <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.src_valid) begin
            for (int unsigned i = 1; i < TPP; i++) r_x[i] <= r_x[i-1];
            r_x[0]      <= bus.src_data;
            r_phase     <= '0;
            r_k         <= '0;
            r_src_ready <= 1'b0;
            r_state     <= ST_MAC;
          end
        end
        ST_MAC: begin
          // Last tap: the final product is folded in through w_sum.
          if (r_k == K_LAST) begin
            r_dest_data  <= w_dest;
            r_dest_valid <= 1'b1;
            r_state      <= ST_EMIT;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        ST_EMIT: begin
          if (bus.dest_ready) begin
            r_dest_valid <= 1'b0;
            if (r_phase == PH_LAST) begin
              r_src_ready <= 1'b1;
              r_state     <= ST_IDLE;
            end else begin
              r_phase <= r_phase + 1'b1;
              r_k     <= '0;
              r_state <= ST_MAC;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  a_acc_starts_clear: assert property (@(posedge clk) disable iff (rst)
    ((r_state == ST_MAC) && (r_k == '0)) |-> (w_acc == '0));

endmodule
